// File: rtl/veririsc_pkg.sv
// Shared VeriRISC encodings: controller phases, opcodes and sequencer states.
// Imported by the sequencer, its IR and the controller decode.
package veririsc_pkg;

    // Controller phases, one per clock of an instruction
    localparam logic [2:0] INST_ADDR  = 3'b000;
    localparam logic [2:0] INST_FETCH = 3'b001;
    localparam logic [2:0] INST_LOAD  = 3'b010;
    localparam logic [2:0] IDLE       = 3'b011;
    localparam logic [2:0] OP_ADDR    = 3'b100;
    localparam logic [2:0] OP_FETCH   = 3'b101;
    localparam logic [2:0] ALU_OP     = 3'b110;
    localparam logic [2:0] STORE      = 3'b111;

    // Instruction opcodes
    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] LDA = 3'b101;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    // Sequencer state encoding
    localparam logic [1:0] ST_PARKED = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    // Phase advance wraps naturally at STORE
    function automatic logic [2:0] phase_inc(input logic [2:0] ph);
        return ph + 3'd1;
    endfunction

endpackage

// File: rtl/veririsc_sequencer_if.sv
// Controller/bus side of the sequencer: strobes and instruction in,
// phase, IR fields and the datapath enable out.
interface veririsc_sequencer_if #(
    parameter int IW = 8,
    parameter int AW = 5
) ();
    logic          mem_rdy;
    logic          rd;
    logic          halt;
    logic          ld_ir;
    logic [IW-1:0] instr_in;
    logic [2:0]    phase;
    logic [2:0]    opcode;
    logic [AW-1:0] ir_addr;
    logic          cpu_en;

    modport master (
        output mem_rdy, rd, halt, ld_ir, instr_in,
        input  phase, opcode, ir_addr, cpu_en
    );

    modport slave (
        input  mem_rdy, rd, halt, ld_ir, instr_in,
        output phase, opcode, ir_addr, cpu_en
    );
endinterface

// File: rtl/veririsc_ir.sv
// Instruction register with load enable and synchronous clear; splits the
// stored word into opcode (top three bits) and operand address fields.
module veririsc_ir #(
    parameter int IW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          load,
    input  logic [IW-1:0] d,
    output logic [2:0]    opcode,
    output logic [AW-1:0] addr
);

    logic [IW-1:0] ir_reg;

    always_ff @(posedge clk) begin
        if (srst)
            ir_reg <= '0;
        else if (load)
            ir_reg <= d;
    end

    assign opcode = ir_reg[IW-1 -: 3];

    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_addr
            assign addr[gi] = ir_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/veririsc_sequencer.sv
// VeriRISC phase sequencer: run/step control, halt freeze/resume, memory
// wait-state stalls and the datapath load enable.
module veririsc_sequencer
    import veririsc_pkg::*;
#(
    parameter int IW = 8,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_mode,
    input  logic                 step,
    input  logic                 resume,
    veririsc_sequencer_if.slave  bus,
    output logic                 halted,
    output logic                 busy
);

    logic [1:0] state_reg, state_next;
    logic [2:0] phase_reg, phase_next;
    logic       in_run;
    logic       stall;
    logic       cpu_en;

    assign in_run = (state_reg == ST_RUN);
    // A read in flight without data holds the whole datapath
    assign stall  = in_run && bus.rd && !bus.mem_rdy;
    assign cpu_en = in_run && !stall;

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        case (state_reg)
            ST_PARKED: begin
                phase_next = INST_ADDR;
                if (run_mode || step)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (cpu_en) begin
                    if (phase_reg == OP_ADDR && bus.halt) begin
                        state_next = ST_HALTED;
                    end else if (phase_reg == STORE) begin
                        phase_next = INST_ADDR;
                        // Mode is only consulted at instruction boundaries
                        if (!run_mode)
                            state_next = ST_PARKED;
                    end else begin
                        phase_next = phase_inc(phase_reg);
                    end
                end
            end
            ST_HALTED: begin
                phase_next = OP_ADDR;
                if (resume) begin
                    state_next = ST_RUN;
                    phase_next = OP_FETCH;
                end
            end
            default: begin
                state_next = ST_PARKED;
                phase_next = INST_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_PARKED;
            phase_reg <= INST_ADDR;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
        end
    end

    veririsc_ir #(
        .IW (IW),
        .AW (AW)
    ) u_ir (
        .clk    (clk),
        .srst   (rst),
        .load   (bus.ld_ir && cpu_en),
        .d      (bus.instr_in),
        .opcode (bus.opcode),
        .addr   (bus.ir_addr)
    );

    assign bus.phase  = phase_reg;
    assign bus.cpu_en = cpu_en;
    assign halted     = (state_reg == ST_HALTED);
    assign busy       = in_run;

endmodule

// File: tb/tb_veririsc_sequencer.sv
// Directed bench for veririsc_sequencer: run, step, halt/resume, stall,
// mid-instruction reset and run_mode drop, with hand-computed expectations.
module tb_veririsc_sequencer;

    logic clk = 1'b0;
    logic rst, run_mode, step, resume;
    logic halted, busy;
    int   total = 0;
    int   bad   = 0;

    veririsc_sequencer_if #(.IW(8), .AW(5)) bus ();

    veririsc_sequencer #(.IW(8), .AW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .run_mode (run_mode),
        .step     (step),
        .resume   (resume),
        .bus      (bus),
        .halted   (halted),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_run(input string tag, input logic [2:0] ph);
        check({tag, " phase"}, 32'(bus.phase), 32'(ph));
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " cpu_en"}, 32'(bus.cpu_en), 32'd1);
    endtask

    task automatic check_parked(input string tag);
        check({tag, " phase"}, 32'(bus.phase), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " cpu_en"}, 32'(bus.cpu_en), 32'd0);
        check({tag, " halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        rst = 1'b1; run_mode = 1'b0; step = 1'b0; resume = 1'b0;
        bus.mem_rdy = 1'b1; bus.rd = 1'b0; bus.halt = 1'b0; bus.ld_ir = 1'b0;
        bus.instr_in = 8'h00;
        tick(); tick();
        check_parked("reset");
        check("reset opcode", 32'(bus.opcode), 32'd0);
        check("reset ir_addr", 32'(bus.ir_addr), 32'd0);

        // Free run with ADD 0x0A: IR loaded on the INST_LOAD edge
        rst = 1'b0; run_mode = 1'b1; bus.instr_in = 8'h4A;
        tick();
        for (int i = 0; i < 9; i++) begin
            check_run($sformatf("run%0d", i), 3'(i % 8));
            check($sformatf("run%0d opcode", i), 32'(bus.opcode), (i >= 3) ? 32'd2 : 32'd0);
            check($sformatf("run%0d ir_addr", i), 32'(bus.ir_addr), (i >= 3) ? 32'h0A : 32'd0);
            bus.ld_ir = ((i % 8) == 2) || ((i % 8) == 3);
            if (i == 8) run_mode = 1'b0;
            tick();
        end
        // run_mode dropped at phase 000: the second instruction still finishes
        for (int i = 1; i < 8; i++) begin
            check_run($sformatf("drain%0d", i), 3'(i));
            tick();
        end
        check_parked("drain parked");
        tick();
        check_parked("parked hold");

        // Single step: exactly eight busy cycles
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_run($sformatf("step%0d", i), 3'(i));
            if (i < 7) tick();
        end
        tick();
        check_parked("step parked");
        tick(); tick();
        check_parked("step parked hold");

        // HLT at OP_ADDR freezes the phase
        bus.instr_in = 8'h00; run_mode = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.ld_ir = (i == 2) || (i == 3);
            tick();
        end
        bus.ld_ir = 1'b0;
        check_run("pre-halt", 3'b100);
        check("pre-halt opcode", 32'(bus.opcode), 32'd0);
        bus.halt = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halt%0d phase", i), 32'(bus.phase), 32'h4);
            check($sformatf("halt%0d halted", i), 32'(halted), 32'd1);
            check($sformatf("halt%0d cpu_en", i), 32'(bus.cpu_en), 32'd0);
            step = (i == 5);
            tick();
        end
        step = 1'b0;
        check("halt step ignored", 32'(halted), 32'd1);
        resume = 1'b1; step = 1'b1;
        tick();
        resume = 1'b0; step = 1'b0; bus.halt = 1'b0;
        check_run("resume", 3'b101);
        check("resume halted", 32'(halted), 32'd0);
        tick(); check_run("resume6", 3'b110);
        tick(); check_run("resume7", 3'b111);
        tick(); check_run("resume0", 3'b000);

        // Stall at INST_FETCH; ld_ir during the stall must not load
        tick();
        check_run("pre-stall", 3'b001);
        bus.rd = 1'b1; bus.mem_rdy = 1'b0; bus.ld_ir = 1'b1; bus.instr_in = 8'hE3;
        #1;
        check("stall cpu_en comb", 32'(bus.cpu_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d phase", i), 32'(bus.phase), 32'h1);
            check($sformatf("stall%0d cpu_en", i), 32'(bus.cpu_en), 32'd0);
            check($sformatf("stall%0d busy", i), 32'(busy), 32'd1);
        end
        bus.mem_rdy = 1'b1; bus.ld_ir = 1'b0;
        #1;
        check("unstall cpu_en", 32'(bus.cpu_en), 32'd1);
        tick();
        bus.rd = 1'b0;
        check_run("post-stall", 3'b010);
        check("post-stall opcode", 32'(bus.opcode), 32'd0);
        bus.ld_ir = 1'b1;
        tick();
        check_run("load E3", 3'b011);
        check("load E3 opcode", 32'(bus.opcode), 32'd7);
        check("load E3 ir_addr", 32'(bus.ir_addr), 32'd3);
        tick();
        bus.ld_ir = 1'b0;
        check("idle reload opcode", 32'(bus.opcode), 32'd7);
        tick(); tick();
        check_run("pre-rst", 3'b110);

        // Reset mid-instruction
        rst = 1'b1; run_mode = 1'b0;
        tick();
        rst = 1'b0;
        check_parked("mid rst");
        check("mid rst opcode", 32'(bus.opcode), 32'd0);
        check("mid rst ir_addr", 32'(bus.ir_addr), 32'd0);

        // run_mode dropped at IDLE: finish and park
        run_mode = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_run($sformatf("drop%0d", i), 3'(i));
            if (i == 3) run_mode = 1'b0;
            tick();
        end
        check_parked("drop parked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
